pred_lead: RTL and testbench

//  Next-generation phase-lead predictor for the DRSSTC feedback path.
//  - Measures the half-period of the synchronous feedback signal sgn.
//  - Once locked, asserts sgn_pre exactly `lead` clocks before the predicted next sgn edge, on both edges.
//  - This compensates gate-driver/IGBT delay. Sits between the feedback synchroniser and the gate drive FSM.
//  - Falls back to 1-cycle passthrough whenever it is not locked.

---
 rtl/pred_lead.sv | 118 +++++++++++
 tb/tb_pred_lead.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pred_lead.sv
// Phase-lead predictor: measures the half-period of sgn and, once locked, toggles sgn_pre `lead` clocks ahead of sgn.
// Optional PRED_AVG_EN predicts from the mean of the last two half-periods instead of the latest one.
module pred_lead #(
   parameter int CNT_W    = 8,
   parameter int LEAD_W   = 8,
   parameter int MIN_HALF = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sgn,
   input  logic [LEAD_W-1:0] lead,
   output logic              sgn_pre,
   output logic              locked,
   output logic [CNT_W-1:0]  half_period
);

   localparam int CMP_W = ((CNT_W > LEAD_W) ? CNT_W : LEAD_W) + 1;
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_TMO = CNT_MAX - ONE;
   localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_HALF);

   typedef enum logic [1:0] {IDLE, ACQ1, ACQ2, LOCK} state_t;

   state_t            state_q;
   logic              sgnDly_q;
   logic              sgnPre_q;
   logic              locked_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  half_q;
   logic [LEAD_W-1:0] lead_q;

   logic              edgeDet;
   logic              measValid;
   logic              timeout;
   logic              targetHit;
   logic [CNT_W-1:0]  cntInc_d;
   logic [CNT_W-1:0]  pred_d;
   logic [CMP_W-1:0]  halfWide;
   logic [CMP_W-1:0]  leadWide;
   logic [CMP_W-1:0]  target;

   assign edgeDet   = sgn ^ sgnDly_q;
   assign measValid = (cnt_q >= MIN_C) && (cnt_q != CNT_MAX);
   assign timeout   = !edgeDet && (cnt_q == CNT_TMO);
   assign cntInc_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + ONE;

   // A lead larger than the half-period clamps the fire point to one clock after the edge.
   assign halfWide  = CMP_W'(half_q);
   assign leadWide  = CMP_W'(lead_q);
   assign target    = (halfWide > leadWide) ? halfWide - leadWide : CMP_W'(1);
   assign targetHit = (CMP_W'(cnt_q) == target);

`ifdef PRED_AVG_EN
   logic [CNT_W-1:0] measPrev_q;
   logic [CNT_W:0]   pairSum;

   // The first stored measurement has no partner yet, so it is used on its own.
   assign pairSum = {1'b0, measPrev_q} + {1'b0, cnt_q};
   assign pred_d  = (state_q == ACQ1) ? cnt_q : CNT_W'(pairSum >> 1);
`else
   assign pred_d  = cnt_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         sgnDly_q <= 1'b0;
         sgnPre_q <= 1'b0;
         locked_q <= 1'b0;
         cnt_q    <= '0;
         half_q   <= '0;
         lead_q   <= '0;
`ifdef PRED_AVG_EN
         measPrev_q <= '0;
`endif
      end else begin
         sgnDly_q <= sgn;
         if (edgeDet) begin
            cnt_q  <= ONE;
            lead_q <= lead;
         end else begin
            cnt_q  <= cntInc_d;
         end

         // Real edges always realign the output; the prediction only fires between edges while locked.
         if (state_q != LOCK || edgeDet || timeout) begin
            sgnPre_q <= sgn;
         end else if (targetHit) begin
            sgnPre_q <= ~sgnDly_q;
         end

         if (edgeDet) begin
            if (state_q == IDLE) begin
               state_q <= ACQ1;
            end else if (measValid) begin
               half_q   <= pred_d;
`ifdef PRED_AVG_EN
               measPrev_q <= cnt_q;
`endif
               state_q  <= (state_q == ACQ1) ? ACQ2 : LOCK;
               locked_q <= (state_q != ACQ1);
            end else begin
               state_q  <= IDLE;
               locked_q <= 1'b0;
            end
         end else if (timeout) begin
            state_q  <= IDLE;
            locked_q <= 1'b0;
         end
      end
   end

   assign sgn_pre     = sgnPre_q;
   assign locked      = locked_q;
   assign half_period = half_q;

endmodule

// File: tb/tb_pred_lead.sv
// Bench for pred_lead: directed scenarios with literal expectations plus random edge spacing,
// all checked every cycle against a measurement-history model of the predictor.
module tb_pred_lead;

   localparam int CNT_MAX  = 255;
   localparam int MIN_HALF = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       sgn;
   logic [7:0] lead;
   logic       sgn_pre;
   logic       locked;
   logic [7:0] half_period;

   int errors = 0;
   int checks = 0;

   pred_lead #(.CNT_W(8), .LEAD_W(8), .MIN_HALF(MIN_HALF)) dut (
      .clk         (clk),
      .rst         (rst),
      .sgn         (sgn),
      .lead        (lead),
      .sgn_pre     (sgn_pre),
      .locked      (locked),
      .half_period (half_period)
   );

   always #5 clk = ~clk;

   // Reference state: time of the last edge, recent valid spacings and the expected outputs.
   int  cyc = 0;
   int  lastEdge = 0;
   int  measQ[$];
   bit  active = 0;
   bit  prevS = 0;
   bit  edgeNow = 0;
   bit  started = 0;
   int  mHalf = 0;
   int  mLeadQ = 0;
   bit  mPre = 0;
   bit  mLocked = 0;

   // Lead actually observed at the most recent edge (edge cycle minus last sgn_pre change).
   int  preChgCyc = 0;
   int  lastLead = 0;
   bit  prevPre = 0;

   function automatic int predictHalf();
`ifdef PRED_AVG_EN
      if (measQ.size() >= 2) return (measQ[measQ.size()-1] + measQ[measQ.size()-2]) / 2;
`endif
      return measQ[measQ.size()-1];
   endfunction

   function automatic int fireAt(int half, int ld);
      return (half > ld) ? half - ld : 1;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Model update on every rising edge using the inputs the DUT samples there.
   always @(posedge clk) begin
      int  d;
      bit  e;
      bit  wasLocked;
      cyc++;
      started = 1;
      edgeNow = 0;
      if (rst) begin
         measQ.delete();
         active   = 0;
         prevS    = 0;
         mHalf    = 0;
         mLeadQ   = 0;
         mPre     = 0;
         mLocked  = 0;
         lastEdge = cyc + 1;
      end else begin
         e = (sgn != prevS);
         d = cyc - lastEdge;
         if (d > CNT_MAX) d = CNT_MAX;
         wasLocked = mLocked;
         if (e) begin
            edgeNow = 1;
            if (!active) begin
               active = 1;
               measQ.delete();
            end else if (d >= MIN_HALF && d < CNT_MAX) begin
               measQ.push_back(d);
               if (measQ.size() > 2) void'(measQ.pop_front());
               mHalf = predictHalf();
            end else begin
               active = 0;
               measQ.delete();
            end
            mLeadQ   = int'(lead);
            lastEdge = cyc;
            mPre     = sgn;
         end else if (d == CNT_MAX - 1) begin
            active = 0;
            measQ.delete();
            mPre   = sgn;
         end else if (!wasLocked) begin
            mPre = sgn;
         end else if (d == fireAt(mHalf, mLeadQ)) begin
            mPre = !prevS;
         end
         prevS   = sgn;
         mLocked = active && (measQ.size() >= 2);
      end
   end

   always @(negedge clk) begin
      if (started) begin
         checkOutput("sgn_pre", int'(sgn_pre), int'(mPre));
         checkOutput("locked", int'(locked), int'(mLocked));
         checkOutput("half_period", int'(half_period), mHalf);
         if (sgn_pre != prevPre) begin
            preChgCyc = cyc;
            prevPre   = sgn_pre;
         end
         if (edgeNow) lastLead = cyc - preChgCyc;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Toggle sgn and hold it for `half` clocks; obsLead is the lead seen at the edge this toggle creates.
   task automatic applyStimulus(input int half, input int midLead, output int obsLead);
      sgn = ~sgn;
      @(posedge clk);
      @(negedge clk);
      #1;
      obsLead = lastLead;
      for (int i = 1; i < half; i++) begin
         if (midLead >= 0 && i == half / 2) lead = 8'(midLead);
         tick();
      end
   endtask

   initial begin
      int ld;
      int r;
      int h;
      int ml;
      rst  = 1'b1;
      sgn  = 1'b0;
      lead = 8'd5;
      repeat (3) tick();
      @(negedge clk);
      #1;
      checkOutput("reset_sgn_pre", int'(sgn_pre), 0);
      checkOutput("reset_locked", int'(locked), 0);
      checkOutput("reset_half_period", int'(half_period), 0);
      rst = 1'b0;
      tick();

      // Square wave, half 20, lead 5.
      applyStimulus(20, -1, ld);
      applyStimulus(20, -1, ld);
      checkOutput("locked_after_2_edges", int'(locked), 0);
      applyStimulus(20, -1, ld);
      checkOutput("locked_after_3_edges", int'(locked), 1);
      checkOutput("half_period_20", int'(half_period), 20);
      applyStimulus(20, -1, ld);
      checkOutput("lead5_first", ld, 5);
      applyStimulus(20, -1, ld);
      checkOutput("lead5_second", ld, 5);

      // Lead larger than the half-period clamps to one clock after the edge.
      lead = 8'd30;
      applyStimulus(20, -1, ld);
      checkOutput("lead30_latch_edge", ld, 5);
      applyStimulus(20, -1, ld);
      checkOutput("lead30_clamped", ld, 19);
      lead = 8'd5;
      applyStimulus(20, -1, ld);
      checkOutput("lead5_restore_edge", ld, 19);
      applyStimulus(20, -1, ld);
      checkOutput("lead5_restored", ld, 5);

      // Half-period drops 20 -> 12.
      applyStimulus(12, -1, ld);
      checkOutput("drop_last_long", ld, 5);
      applyStimulus(12, -1, ld);
      checkOutput("drop_first_short", ld, 0);
`ifdef PRED_AVG_EN
      checkOutput("drop_half_avg", int'(half_period), 16);
      applyStimulus(12, -1, ld);
      checkOutput("drop_second_short", ld, 1);
`else
      checkOutput("drop_half", int'(half_period), 12);
      applyStimulus(12, -1, ld);
      checkOutput("drop_second_short", ld, 5);
`endif
      applyStimulus(12, -1, ld);
      checkOutput("drop_third_short", ld, 5);

      // Glitch: a 2-clock pulse drops lock, three more edges relock.
      applyStimulus(6, -1, ld);
      applyStimulus(2, -1, ld);
      applyStimulus(8, -1, ld);
      checkOutput("glitch_unlock", int'(locked), 0);
      applyStimulus(20, -1, ld);
      applyStimulus(20, -1, ld);
      checkOutput("glitch_acq", int'(locked), 0);
      applyStimulus(20, -1, ld);
      checkOutput("glitch_relock", int'(locked), 1);

      // Timeout: sgn held long enough for the counter to saturate.
      applyStimulus(253, -1, ld);
      tick();
      @(negedge clk);
      checkOutput("timeout_before", int'(locked), 1);
      tick();
      @(negedge clk);
      checkOutput("timeout_unlock", int'(locked), 0);
      checkOutput("timeout_follow", int'(sgn_pre), int'(sgn));

      // Reset while locked.
      repeat (4) applyStimulus(20, -1, ld);
      checkOutput("prereset_locked", int'(locked), 1);
      applyStimulus(7, -1, ld);
      rst = 1'b1;
      tick();
      @(negedge clk);
      checkOutput("midreset_sgn_pre", int'(sgn_pre), 0);
      checkOutput("midreset_locked", int'(locked), 0);
      checkOutput("midreset_half", int'(half_period), 0);
      rst = 1'b0;
      tick();
      repeat (4) applyStimulus(20, -1, ld);

      // Random spacing, leads, mid-half lead changes, glitches, timeouts and resets.
      for (int n = 0; n < 200; n++) begin
         r = int'($urandom_range(0, 99));
         if (r < 3) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            tick();
         end else begin
            if (r < 9)       h = int'($urandom_range(1, 3));
            else if (r < 12) h = int'($urandom_range(240, 270));
            else             h = int'($urandom_range(4, 32));
            if ($urandom_range(0, 4) == 0) lead = 8'($urandom_range(0, 40));
            ml = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 40)) : -1;
            applyStimulus(h, ml, ld);
         end
      end
      repeat (5) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
